// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mem_arb_pkg;

    // Largest supported fixed memory read latency.
    localparam int ARB_LAT_MAX = 15;
    // Width of the completion down-counter; holds values up to ARB_LAT_MAX-1.
    localparam int ARB_CNT_W   = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch port, data port and shared memory port signals.
// Latency: none, wiring only.
// Backpressure: requesters hold req and fields until their ready pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    // Arbiter side: takes requests and memory read data, drives the rest.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_addr, m_wdata
    );

    // Requesters plus memory: the mirror image of the arbiter side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// Grant selection between fetch and data requesters (ARB_ROUND_ROBIN_EN selects round robin).
// Latency: purely combinational.
// Backpressure: none; the loser simply keeps requesting.
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_owner_e last_i,
`endif
    output arb_owner_e gnt_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt_o = OWN_I;
        if (i_req_i && d_req_i) begin
            gnt_o = (last_i == OWN_D) ? OWN_I : OWN_D;
        end else if (d_req_i) begin
            gnt_o = OWN_D;
        end
    end
`else
    // Data port always wins a tie: it carries the older instruction.
    always_comb begin
        gnt_o = OWN_I;
        if (d_req_i) begin
            gnt_o = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency memory (ARB_ROUND_ROBIN_EN: fair tie-break).
// Latency: ready LAT cycles after the issue cycle; one access per LAT+1 cycles.
// Backpressure: requester sees req & ~ready as a stall; new requests wait for IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1    // legal 1..ARB_LAT_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    arb_state_e           state_q, state_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    arb_owner_e           owner_q, owner_d;
    arb_owner_e           gnt;
    logic                 issue;
    logic                 done;
    logic [ADDR_W-1:0]    addr_mux;
    logic [DATA_W-1:0]    wdata_mux;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_e           last_q, last_d;
`endif

    arb_grant u_grant (
        .i_req_i (bus.i_req),
        .d_req_i (bus.d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_i  (last_q),
`endif
        .gnt_o   (gnt)
    );

    // Reset gates the issue so the strobe drops the moment reset rises.
    assign issue = ~reset & (state_q == ARB_IDLE) & (bus.i_req | bus.d_req);
    assign done  = (state_q == ARB_WAIT) && (cnt_q == '0);

    // Next-state: take a grant in IDLE, count down in WAIT, leave on the completion cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (issue) begin
                    state_d = ARB_WAIT;
                    cnt_d   = ARB_CNT_W'(LAT - 1);
                    owner_d = gnt;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = gnt;
`endif
                end
            end
            ARB_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q - ARB_CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // FSM registers; an asynchronous reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // Memory port is driven from the granted requester only during the issue cycle.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        if (issue) begin
            if (gnt == OWN_D) begin
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_wdata;
            end else begin
                addr_mux  = bus.i_addr;
            end
        end
    end

    assign bus.m_en    = issue;
    assign bus.m_we    = issue & (gnt == OWN_D) & bus.d_we;
    assign bus.m_addr  = addr_mux;
    assign bus.m_wdata = wdata_mux;

    // Completion pulses go to the registered owner; read data is forwarded straight through.
    assign bus.i_ready = done & (owner_q == OWN_I);
    assign bus.d_ready = done & (owner_q == OWN_D);
    assign bus.i_rdata = bus.i_ready ? bus.m_rdata : '0;
    assign bus.d_rdata = bus.d_ready ? bus.m_rdata : '0;

endmodule
